idct_col_sched: RTL and testbench
=================================

Name: idct_col_sched

Overview:
- Sequencer for the column stage of the 8x8 IDCT.
- Collects eight 128-bit intermediate row vectors (8 x 16-bit) from the row stage into a transpose buffer.
- Issues the eight transposed column vectors to the column datapath and captures its 64-bit pixel results after a fixed pipeline latency.
- Streams the eight pixel vectors out under valid/ready; one block in flight at a time.

Parameters:
- COL_LAT, 1: cycles from col_valid/col_data to the matching col_pix sample; legal range 1..4.
- W, 16: width of one intermediate coefficient; the vector is 8*W bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  row vector available.
- in_ready  out  1  block accepts a row vector.
- in_data  in  8*W  row vector; element k is at bits [k*W +: W].
- col_valid  out  1  col_data carries an issued column this cycle.
- col_data  out  8*W  transposed column to the datapath; element r is at [r*W +: W] and equals row r, element c.
- col_pix  in  64  datapath result, sampled COL_LAT cycles after the matching col_valid.
- out_valid  out  1  pixel vector available.
- out_ready  in  1  sink accepts.
- out_data  out  64  pixel vector for column c.
- out_last  out  1  high with out_data of column 7.
- busy  out  1  high in ISSUE, WAIT and OUT states.
- block_done  out  1  one-cycle pulse when the column-7 output is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; row, col and output counters = 0; delay pipe cleared.
  - in_ready=1. col_valid, out_valid, out_last, busy and block_done = 0.
  - col_data and out_data = 0. Buffer contents are don't-care.
  - Reset mid-operation abandons the block and emits nothing further.
- LOAD:
  - in_ready=1. A transfer occurs when in_valid&in_ready; row_cnt selects the write row, and the counter increments.
  - The transfer at row_cnt=7 moves the state to ISSUE on the next cycle and drives in_ready=0 from that cycle.
  - in_valid=0 leaves state and counters unchanged.
- ISSUE:
  - Runs exactly 8 consecutive cycles with col_valid=1 and col_cnt=0..7.
  - col_data is registered from the buffer, so the issued column is stable during its col_valid cycle.
  - There is no backpressure from the datapath. After col_cnt=7 the state moves to WAIT.
- Capture:
  - A COL_LAT-deep shift register carries valid and column index alongside the datapath.
  - When the delayed valid is set, col_pix is written to out_buf[delayed index].
  - Captures overlap ISSUE and WAIT.
- WAIT:
  - Holds until the capture of column 7 completes, i.e. COL_LAT cycles after the last issue.
  - The state moves to OUT on the cycle after that capture.
- OUT:
  - out_valid=1 and out_data=out_buf[out_cnt]; out_last=(out_cnt==7).
  - out_data is held stable while out_valid&!out_ready.
  - On out_valid&out_ready, out_cnt increments.
  - At out_cnt=7: block_done pulses, the state returns to LOAD, and in_ready=1 on the following cycle.
- Latency: the first out_valid is 8+COL_LAT+1 cycles after the cycle that accepted row 7.
- in_valid during ISSUE/WAIT/OUT is ignored, since in_ready=0.
- out_ready asserted outside OUT has no effect.
- Counters wrap 7->0 at each state exit and are never left out of range.
- Arithmetic: no arithmetic on data; pure routing and storage. Pixel bytes pass through unmodified.

Test Plan:
- Reset release, then rows with element (r,c)=r*8+c -> the col_valid cycle for c=3 shows col_data elements {3,11,19,...,59}; busy=1 for all 8 issue cycles.
- Model datapath col_pix = 8'hA0+c in every byte, COL_LAT=1 and COL_LAT=4 -> out_data sequence 0xA0A0.., 0xA1A1.., ..., 0xA7A7..; out_last only on 0xA7A7..; first out_valid 10 and 13 cycles after the row-7 accept respectively.
- Sink holds out_ready=0 for 5 cycles at column 2 -> out_data stays at column 2, no skipped or duplicated column; block_done pulses once, on the column-7 accept.
- in_valid held high throughout two back-to-back blocks -> exactly 8 accepts per block; in_ready=0 from ISSUE until block_done+1.
- in_valid gaps between rows (rows 0-3, idle 3 cycles, rows 4-7) -> ISSUE starts only after row 7; output identical to the gapless case.
- rst_n low during OUT at column 4, then a new block -> out_valid=0 at once (async); the new block outputs its own data starting at column 0.

Source files
------------

// File: rtl/idct_col_sched_if.sv
// Row-in / column-issue / pixel-out bundle between the IDCT row stage, the
// column sequencer, the column datapath and the pixel sink.
interface idct_col_sched_if #(parameter int W = 16) ();
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] in_data;
  logic           col_valid;
  logic [8*W-1:0] col_data;
  logic [63:0]    col_pix;
  logic           out_valid;
  logic           out_ready;
  logic [63:0]    out_data;
  logic           out_last;

  modport master (
    output in_valid, in_data, col_pix, out_ready,
    input  in_ready, col_valid, col_data, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, col_pix, out_ready,
    output in_ready, col_valid, col_data, out_valid, out_data, out_last
  );
endinterface

// File: rtl/idct_col_sched.sv
// Column-stage sequencer for the 8x8 IDCT: transpose buffer, column issue,
// fixed-latency result capture and pixel streaming, one block at a time.
//
// state   | meaning
// LOAD    | accepting row vectors 0..7 into the transpose buffer
// ISSUE   | 8 cycles driving columns 0..7 to the datapath
// WAIT    | draining the datapath until column 7 is captured
// OUT     | streaming pixel vectors 0..7 to the sink
module idct_col_sched #(
  parameter int COL_LAT = 1,
  parameter int W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  idct_col_sched_if.slave   bus,
  output logic              busy,
  output logic              block_done
);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t             state;
  logic [2:0]         row_cnt;
  logic [2:0]         col_cnt;
  logic [2:0]         out_cnt;
  logic [8*W-1:0]     row_buf [8];
  logic [63:0]        out_buf [8];
  logic [COL_LAT-1:0] dly_v;
  logic [2:0]         dly_c [COL_LAT];
  logic [2:0]         nxt_col;
  logic [8*W-1:0]     col_next;
  logic               accept;
  logic               last_cap;

  assign accept     = (state == S_LOAD) && bus.in_valid;
  assign last_cap   = dly_v[COL_LAT-1] && (dly_c[COL_LAT-1] == 3'd7);
  assign block_done = bus.out_valid & bus.out_ready & bus.out_last;

  // Column 0 is registered on the row-7 accept edge, so row 7 bypasses the buffer.
  always_comb begin
    nxt_col  = (state == S_LOAD) ? 3'd0 : col_cnt + 3'd1;
    col_next = '0;
    for (int r = 0; r < 8; r++) begin
      if (state == S_LOAD && r == 7)
        col_next[r*W +: W] = bus.in_data[0 +: W];
      else
        col_next[r*W +: W] = row_buf[r][nxt_col*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_LOAD;
      row_cnt       <= '0;
      col_cnt       <= '0;
      out_cnt       <= '0;
      busy          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.col_valid <= 1'b0;
      bus.col_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (bus.in_valid) begin
            row_cnt <= row_cnt + 3'd1;
            if (row_cnt == 3'd7) begin
              state         <= S_ISSUE;
              busy          <= 1'b1;
              bus.in_ready  <= 1'b0;
              bus.col_valid <= 1'b1;
              bus.col_data  <= col_next;
              col_cnt       <= 3'd0;
            end
          end
        end
        S_ISSUE: begin
          if (col_cnt == 3'd7) begin
            state         <= S_WAIT;
            col_cnt       <= 3'd0;
            bus.col_valid <= 1'b0;
            bus.col_data  <= '0;
          end else begin
            col_cnt      <= col_cnt + 3'd1;
            bus.col_data <= col_next;
          end
        end
        S_WAIT: begin
          if (last_cap) begin
            state         <= S_OUT;
            out_cnt       <= 3'd0;
            bus.out_valid <= 1'b1;
            bus.out_data  <= out_buf[0];
            bus.out_last  <= 1'b0;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (out_cnt == 3'd7) begin
              state         <= S_LOAD;
              out_cnt       <= 3'd0;
              busy          <= 1'b0;
              bus.in_ready  <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_data  <= '0;
              bus.out_last  <= 1'b0;
            end else begin
              out_cnt      <= out_cnt + 3'd1;
              bus.out_data <= out_buf[out_cnt + 3'd1];
              bus.out_last <= (out_cnt == 3'd6);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Valid/index shadow of the datapath pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_v <= '0;
      for (int i = 0; i < COL_LAT; i++) dly_c[i] <= '0;
    end else begin
      dly_v[0] <= bus.col_valid;
      dly_c[0] <= col_cnt;
      for (int i = 1; i < COL_LAT; i++) begin
        dly_v[i] <= dly_v[i-1];
        dly_c[i] <= dly_c[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) row_buf[row_cnt] <= bus.in_data;
    if (dly_v[COL_LAT-1]) out_buf[dly_c[COL_LAT-1]] <= bus.col_pix;
  end

endmodule

// File: tb/tb_idct_col_sched.sv
// Directed bench for idct_col_sched: transpose, latency for COL_LAT=1/4,
// sink stalls, back-to-back blocks, row gaps and reset during output.
module tb_idct_col_sched;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idct_col_sched_if #(.W(W)) b1 ();
  idct_col_sched_if #(.W(W)) b4 ();
  logic busy1, busy4, done1, done4;

  idct_col_sched #(.COL_LAT(1), .W(W)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .busy(busy1), .block_done(done1));
  idct_col_sched #(.COL_LAT(4), .W(W)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave), .busy(busy4), .block_done(done4));

  logic           iv [2];
  logic [8*W-1:0] idat [2];
  logic           ordy [2];
  logic [7:0]     pix_base [2];
  logic [2:0]     ic [2];
  logic [2:0]     pc [2][4];
  logic [7:0]     pb1, pb4;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};

  assign b1.in_valid  = iv[0];
  assign b1.in_data   = idat[0];
  assign b1.out_ready = ordy[0];
  assign b4.in_valid  = iv[1];
  assign b4.in_data   = idat[1];
  assign b4.out_ready = ordy[1];
  assign pb1 = pix_base[0] + {5'd0, pc[0][0]};
  assign pb4 = pix_base[1] + {5'd0, pc[1][3]};
  assign b1.col_pix = {8{pb1}};
  assign b4.col_pix = {8{pb4}};

  // Datapath model: each column yields byte base+c, COL_LAT cycles after issue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic[0] <= 3'd0;
      ic[1] <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        pc[0][i] <= 3'd0;
        pc[1][i] <= 3'd0;
      end
    end else begin
      if (b1.col_valid) ic[0] <= ic[0] + 3'd1;
      if (b4.col_valid) ic[1] <= ic[1] + 3'd1;
      pc[0][0] <= ic[0];
      pc[1][0] <= ic[1];
      for (int i = 1; i < 4; i++) begin
        pc[0][i] <= pc[0][i-1];
        pc[1][i] <= pc[1][i-1];
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b1.in_valid && b1.in_ready) acc_cnt[0] <= acc_cnt[0] + 1;
    if (b4.in_valid && b4.in_ready) acc_cnt[1] <= acc_cnt[1] + 1;
    if (done1) done_cnt[0] <= done_cnt[0] + 1;
    if (done4) done_cnt[1] <= done_cnt[1] + 1;
  end

  function automatic logic ov(input int s); return (s == 1) ? b4.out_valid : b1.out_valid; endfunction
  function automatic logic ol(input int s); return (s == 1) ? b4.out_last : b1.out_last; endfunction
  function automatic logic ir(input int s); return (s == 1) ? b4.in_ready : b1.in_ready; endfunction
  function automatic logic cv(input int s); return (s == 1) ? b4.col_valid : b1.col_valid; endfunction
  function automatic logic bz(input int s); return (s == 1) ? busy4 : busy1; endfunction
  function automatic logic bd(input int s); return (s == 1) ? done4 : done1; endfunction
  function automatic logic [63:0] od(input int s); return (s == 1) ? b4.out_data : b1.out_data; endfunction
  function automatic logic [8*W-1:0] cd(input int s); return (s == 1) ? b4.col_data : b1.col_data; endfunction

  function automatic logic [8*W-1:0] row_val(input int r, input int seed);
    logic [8*W-1:0] v;
    for (int c = 0; c < 8; c++) v[c*W +: W] = 16'(r*8 + c + seed);
    return v;
  endfunction

  function automatic logic [8*W-1:0] exp_col(input int c, input int seed);
    logic [8*W-1:0] v;
    for (int r = 0; r < 8; r++) v[r*W +: W] = 16'(r*8 + c + seed);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_block(input int s, input int seed, input bit gap, output int acc_cyc);
    int n;
    acc_cyc = 0;
    for (int r = 0; r < 8; r++) begin
      if (gap && r == 4) begin
        iv[s] = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("gap_col_valid", cv(s), 1'b0);
          chk("gap_busy", bz(s), 1'b0);
        end
      end
      iv[s] = 1'b1;
      idat[s] = row_val(r, seed);
      n = 0;
      while (!ir(s) && n < 50) begin @(negedge clk); n++; end
      chk("in_ready_wait", ir(s), 1'b1);
      acc_cyc = cyc;
      @(negedge clk);
    end
    iv[s] = 1'b0;
  endtask

  task automatic watch_issue(input int s, input int seed);
    for (int c = 0; c < 8; c++) begin
      chk("issue_valid", cv(s), 1'b1);
      chk("issue_busy", bz(s), 1'b1);
      chk("issue_in_ready", ir(s), 1'b0);
      chk("issue_col_data", cd(s), exp_col(c, seed));
      @(negedge clk);
    end
    chk("issue_end", cv(s), 1'b0);
  endtask

  task automatic collect(input int s, input logic [7:0] base, input int stall_col,
                         input int stall_n, input int stop_at, output int first_cyc);
    int n;
    first_cyc = 0;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!ov(s) && n < 100) begin @(negedge clk); n++; end
      chk("out_valid_wait", ov(s), 1'b1);
      if (k == 0) first_cyc = cyc;
      chk("out_data", od(s), {8{base + 8'(k)}});
      if (k == stop_at) return;
      if (k == stall_col) begin
        ordy[s] = 1'b0;
        for (int i = 0; i < stall_n; i++) begin
          @(negedge clk);
          chk("stall_valid", ov(s), 1'b1);
          chk("stall_data", od(s), {8{base + 8'(k)}});
          chk("stall_done", bd(s), 1'b0);
        end
        ordy[s] = 1'b1;
        #1;
      end
      chk("out_last", ol(s), (k == 7));
      chk("block_done", bd(s), (k == 7));
      chk("out_in_ready", ir(s), 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    int acc, first, d0, a0;
    iv = '{1'b0, 1'b0};
    idat = '{'0, '0};
    ordy = '{1'b1, 1'b1};
    pix_base = '{8'hA0, 8'hA0};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_in_ready", ir(s), 1'b1);
      chk("rst_col_valid", cv(s), 1'b0);
      chk("rst_out_valid", ov(s), 1'b0);
      chk("rst_out_last", ol(s), 1'b0);
      chk("rst_busy", bz(s), 1'b0);
      chk("rst_block_done", bd(s), 1'b0);
      chk("rst_col_data", cd(s), '0);
      chk("rst_out_data", od(s), '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Transpose, data and latency for both pipeline depths
    for (int s = 0; s < 2; s++) begin
      d0 = done_cnt[s];
      load_block(s, 0, 1'b0, acc);
      watch_issue(s, 0);
      collect(s, 8'hA0, -1, 0, 8, first);
      chk("latency", first - acc, (s == 1) ? 13 : 10);
      chk("done_once", done_cnt[s] - d0, 1);
    end

    // Sink stall at column 2
    d0 = done_cnt[0];
    load_block(0, 0, 1'b0, acc);
    collect(0, 8'hA0, 2, 5, 8, first);
    chk("stall_latency", first - acc, 10);
    chk("stall_done_once", done_cnt[0] - d0, 1);

    // in_valid held high over two back-to-back blocks
    a0 = acc_cnt[0];
    d0 = done_cnt[0];
    iv[0] = 1'b1;
    idat[0] = row_val(0, 0);
    collect(0, 8'hA0, -1, 0, 8, first);
    chk("b2b_acc_block1", acc_cnt[0] - a0, 8);
    chk("b2b_ready_after_done", ir(0), 1'b1);
    collect(0, 8'hA0, -1, 0, 8, first);
    iv[0] = 1'b0;
    @(negedge clk);
    chk("b2b_acc_block2", acc_cnt[0] - a0, 16);
    chk("b2b_done", done_cnt[0] - d0, 2);

    // Gaps between rows 3 and 4
    load_block(0, 0, 1'b1, acc);
    watch_issue(0, 0);
    collect(0, 8'hA0, -1, 0, 8, first);
    chk("gap_latency", first - acc, 10);

    // Reset while column 4 is presented, then a fresh block
    load_block(0, 0, 1'b0, acc);
    collect(0, 8'hA0, -1, 0, 4, first);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", ov(0), 1'b0);
    chk("arst_out_data", od(0), '0);
    chk("arst_busy", bz(0), 1'b0);
    chk("arst_in_ready", ir(0), 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    pix_base[0] = 8'hB0;
    @(negedge clk);
    chk("post_rst_out_valid", ov(0), 1'b0);
    d0 = done_cnt[0];
    load_block(0, 16'h100, 1'b0, acc);
    watch_issue(0, 16'h100);
    collect(0, 8'hB0, -1, 0, 8, first);
    chk("post_rst_latency", first - acc, 10);
    chk("post_rst_done", done_cnt[0] - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
